// File: rtl/paralelo_serial_pkg.sv
// rtl/paralelo_serial_pkg.sv - shared constants and FSM encoding for the parallel-to-serial generator
// Holds the default word width, idle pattern and sync length used as
// parameter defaults, plus the INIT/RUN state type.
package paralelo_serial_pkg;

    localparam int         PS_DEFAULT_WIDTH        = 8;
    localparam logic [7:0] PS_DEFAULT_IDLE_PATTERN = 8'hBC;
    localparam int         PS_DEFAULT_SYNC_WORDS   = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ps_state_t;

endpackage

// File: rtl/contador_bits.sv
// rtl/contador_bits.sv - modulo-N bit position counter with end-of-frame flag
// Ports:
//   clk      : bit-rate clock
//   reset    : asynchronous active-high reset, forces count to 0
//   count    : current bit position, 0..MODULO-1
//   boundary : high while count sits on the last bit position (MODULO-1)
module contador_bits #(
    parameter int MODULO = 8,
    parameter int CNT_W  = $clog2(MODULO)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] count,
    output logic             boundary
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign boundary = (count_q == CNT_W'(MODULO - 1));
    assign count    = count_q;

    always_comb begin
        count_d = boundary ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/paralelo_serial_gen.sv
// rtl/paralelo_serial_gen.sv - parallel word to MSB-first serial stream with idle fill and sync preamble
// After reset it sends SYNC_WORDS idle frames, then accepts words through a
// one-entry holding register and serialises them; idle frames fill any gap.
// Optional build macro PS_PARITY_EN appends an even-parity bit to every frame.
// Ports:
//   clk_32f    : bit-rate clock
//   reset      : asynchronous active-high reset
//   data_in    : parallel word, taken when valid_in && ready_out
//   valid_in   : upstream word-valid strobe
//   ready_out  : holding register can take a word this cycle
//   data_out   : serial bit, registered MSB of the shift register
//   word_start : high while data_out carries the first bit of a frame
//   sync_done  : high once the idle preamble has completed
module paralelo_serial_gen
    import paralelo_serial_pkg::*;
#(
    parameter int               WIDTH        = PS_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = WIDTH'(PS_DEFAULT_IDLE_PATTERN),
    parameter int               SYNC_WORDS   = PS_DEFAULT_SYNC_WORDS
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             word_start,
    output logic             sync_done
);

`ifdef PS_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME);
    localparam int FC_W  = $clog2(SYNC_WORDS + 1);

    // Shift-register image of one frame: the word, plus its parity bit in
    // the LSB position when parity is built in.
    function automatic logic [FRAME-1:0] frame_word(input logic [WIDTH-1:0] w);
`ifdef PS_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    logic [FRAME-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    ps_state_t        state_q, state_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic [CNT_W-1:0] bit_cnt;
    logic             boundary;
    logic             accept;

    contador_bits #(
        .MODULO (FRAME),
        .CNT_W  (CNT_W)
    ) u_contador_bits (
        .clk      (clk_32f),
        .reset    (reset),
        .count    (bit_cnt),
        .boundary (boundary)
    );

    // On the boundary the holding word drains into the shift register, so the
    // slot frees up in the same cycle and a new word may land behind it.
    assign ready_out  = (state_q == RUN) && (!hold_valid_q || boundary);
    assign accept     = valid_in && ready_out;
    assign data_out   = shift_q[FRAME-1];
    assign word_start = (bit_cnt == '0);
    assign sync_done  = (state_q == RUN);

    always_comb begin
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;

        if (boundary) begin
            shift_d      = hold_valid_q ? frame_word(hold_q) : frame_word(IDLE_PATTERN);
            hold_valid_d = 1'b0;
            if (state_q == INIT) begin
                if (frame_cnt_q == FC_W'(SYNC_WORDS - 1)) begin
                    state_d = RUN;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end else begin
            shift_d = {shift_q[FRAME-2:0], 1'b0};
        end

        if (accept) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            shift_q      <= frame_word(IDLE_PATTERN);
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            state_q      <= INIT;
            frame_cnt_q  <= '0;
        end else begin
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

endmodule

// File: doc/paralelo_serial_gen.md
PARALELO_SERIAL_GEN -- requirements
Module: paralelo_serial_gen

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits, minimum 2.
REQ-002 Parameter IDLE_PATTERN, default 8'hBC (WIDTH bits): word transmitted when no data is pending.
REQ-003 Parameter SYNC_WORDS, default 4: number of idle words sent after reset before data is accepted, minimum 1.
REQ-004 clk_32f  input  1: single bit-rate clock; all state changes on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 data_in  input  WIDTH: parallel word, sampled when valid_in and ready_out are both high.
REQ-007 valid_in  input  1: upstream word-valid strobe.
REQ-008 ready_out  output  1: holding register can accept a word this cycle.
REQ-009 data_out  output  1: serial stream, MSB first.
REQ-010 word_start  output  1: high on the cycle data_out carries bit 0 (MSB) of a frame.
REQ-011 sync_done  output  1: high once SYNC_WORDS idle frames have completed.

Function
REQ-012 FRAME = WIDTH bits, or WIDTH+1 when PS_PARITY_EN is defined; bit counter runs 0..FRAME-1 and wraps to 0.
REQ-013 data_out SHALL be the registered MSB of the shift register; no combinational path from any input to data_out.
REQ-014 When counter is below FRAME-1: shift register shifts left one bit; counter increments.
REQ-015 When counter equals FRAME-1 (boundary): shift register loads the holding word if hold_valid, else IDLE_PATTERN; hold_valid clears when the holding word is consumed; counter returns to 0.
REQ-016 word_start SHALL be high exactly when counter equals 0.
REQ-017 FSM states: INIT, RUN. INIT counts completed frames; on the boundary ending frame SYNC_WORDS it moves to RUN. RUN is held until reset.
REQ-018 ready_out = (state==RUN) and (not hold_valid, or boundary this cycle).
REQ-019 Accept on valid_in and ready_out: data_in written to holding register, hold_valid set; when accept and boundary coincide, the old holding word goes to the shift register and the new word takes the holding register.
REQ-020 valid_in while ready_out is low SHALL be ignored; the holding register is unchanged.
REQ-021 Latency: a word accepted with hold empty appears MSB-first starting on the cycle after the next boundary.
REQ-022 sync_done SHALL equal (state==RUN).

Reset
REQ-023 Reset sets: shift register = IDLE_PATTERN, counter = 0, hold_valid = 0, state = INIT, frame count = 0.
REQ-024 Output values in reset: data_out = IDLE_PATTERN[WIDTH-1], word_start = 1, ready_out = 0, sync_done = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, discard any held word, and restart the idle sync sequence.

Configuration
REQ-026 Macro PS_PARITY_EN defined: each frame is followed by one even-parity bit (XOR of all WIDTH bits), idle frames included.
REQ-027 PS_PARITY_EN undefined: no parity bit, FRAME = WIDTH, and no parity logic is synthesised.

Structure
REQ-028 Package paralelo_serial_pkg holds the default WIDTH, IDLE_PATTERN and SYNC_WORDS constants and the INIT/RUN state encoding.
REQ-029 Sub-module contador_bits (parametrised modulo-FRAME counter with a boundary flag) SHALL be instantiated for the bit counter.

Verification (WIDTH=8, IDLE=8'hBC, SYNC_WORDS=4, parity off unless noted)
REQ-030 Reset release, valid_in=0 -> data_out repeats 1,0,1,1,1,1,0,0; ready_out low for 32 cycles, then high; sync_done rises on cycle 32.
REQ-031 After sync, send FF then EE back-to-back -> serial 11111111 then 11101110 on consecutive frames; ready_out low while the holding register is full.
REQ-032 Hold full with 8'h3C; present 8'h81 on the boundary cycle -> 81 accepted, 3C sent on the next frame, then 10000001.
REQ-033 Reset pulse at bit 4 of an 8'hFF frame -> data_out = 1 (BC MSB) at once, word_start = 1, held word lost, ready_out low for another 32 cycles.
REQ-034 PS_PARITY_EN defined, send A5 then 07 -> 101001010 then 000001111; idle frame = 101111001.
